// File: rtl/mem_wait_responder.sv
// Slow-memory responder for the CPU load/store port: one word request at a time,
// completed with a one-cycle ready pulse after LAT wait states.
module mem_wait_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LAT   = 2,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned CW = $clog2(LAT + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One past the last valid byte address; 33 bits so a top-of-space window cannot wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q;
  logic [3:0]    be_q;
  logic [31:0]   addr_q, wdata_q;

  logic [31:0] data [DEPTH];

  logic [31:0]   offset;
  logic [AW-1:0] idx;
  logic          bad;
  logic          access;
  logic          unused_offset;

  assign offset        = addr_q - BASE;
  assign idx           = offset[AW+1:2];
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};
  assign bad           = (addr_q[1:0] != 2'b00) || (addr_q < BASE) || ({1'b0, addr_q} >= LIMIT);
  assign access        = (state_q == StBusy) && (cnt_q == '0);
  assign busy          = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StBusy;
          cnt_d   = CW'(LAT - 1);
        end
      end
      StBusy: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else             state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= access;
      err     <= access && bad;
      if (access) rdata <= (bad || we_q) ? 32'h0 : data[idx];
      if (state_q == StIdle && req) begin
        we_q    <= we;
        be_q    <= be;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
    end
  end

  // Array is not reset; an aborted write never reaches access because reset clears state_q.
  always_ff @(posedge clk) begin
    if (access && we_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) data[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Scoreboard bench for mem_wait_responder: driver pushes expected responses,
// a negedge monitor pops and checks them whenever ready is seen.
module tb_mem_wait_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, req1 = 1'b0, req4 = 1'b0, we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata, rdata1, rdata4;
  logic        ready, err, busy, ready1, err1, busy1, ready4, err4, busy4;

  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_wait_responder #(.DEPTH(256), .LAT(LAT), .BASE(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .err(err), .busy(busy)
  );
  mem_wait_responder #(.DEPTH(256), .LAT(1), .BASE(32'h0)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .ready(ready1), .err(err1), .busy(busy1)
  );
  mem_wait_responder #(.DEPTH(256), .LAT(4), .BASE(32'h0)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .rdata(rdata4), .ready(ready4), .err(err4), .busy(busy4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", {31'b0, ready}, 32'h0);
        end else begin
          mon_e = sb.pop_front();
          check("rdata", rdata, mon_e.rdata);
          check("err", {31'b0, err}, {31'b0, mon_e.err});
          check("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("busy_in_resp", {31'b0, busy}, 32'h1);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while ((busy !== 1'b0 || ready !== 1'b0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("idle_timeout", 32'(k), 32'h0);
  endtask

  task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] d, input logic exp_err, input logic [31:0] exp_rd);
    wait_idle();
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    @(posedge clk);
    #1;
    sb.push_back('{rdata: exp_rd, err: exp_err, cyc: cyc + int'(LAT)});
    @(negedge clk);
    req = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'h1);
  endtask

  int n, r1, r4, p1, p4;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_ready", {31'b0, ready}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // Basic write then read of word 3
    issue(1'b1, 4'hF, 32'hC, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(1'b0, 4'h0, 32'hC, 32'h0, 1'b0, 32'hDEADBEEF);

    // Partial byte-enable write
    issue(1'b1, 4'hF, 32'h10, 32'h0, 1'b0, 32'h0);
    issue(1'b1, 4'b0101, 32'h10, 32'h11223344, 1'b0, 32'h0);
    issue(1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 32'h00220044);
    wait_idle();
    check("data4_array", dut.data[4], 32'h00220044);

    // Error cases and range boundary
    issue(1'b0, 4'h0, 32'h6, 32'h0, 1'b1, 32'h0);
    issue(1'b0, 4'h0, 32'h400, 32'h0, 1'b1, 32'h0);
    issue(1'b1, 4'hF, 32'h0, 32'hA5A5A5A5, 1'b0, 32'h0);
    issue(1'b1, 4'hF, 32'h4, 32'h0BADF00D, 1'b0, 32'h0);
    issue(1'b1, 4'hF, 32'h400, 32'h12345678, 1'b1, 32'h0);
    issue(1'b1, 4'hF, 32'h3FC, 32'hCAFEF00D, 1'b0, 32'h0);
    issue(1'b0, 4'h0, 32'h3FC, 32'h0, 1'b0, 32'hCAFEF00D);
    issue(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'hA5A5A5A5);

    // req held high across two back-to-back reads
    wait_idle();
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0;
    @(posedge clk);
    #1;
    n = cyc;
    sb.push_back('{rdata: 32'hA5A5A5A5, err: 1'b0, cyc: n + int'(LAT)});
    sb.push_back('{rdata: 32'h0BADF00D, err: 1'b0, cyc: n + 2 * int'(LAT) + 2});
    @(negedge clk);
    addr = 32'h4;
    while (cyc < n + int'(LAT) + 2) @(negedge clk);
    req = 1'b0;

    // Reset in the middle of a write
    issue(1'b1, 4'hF, 32'h8, 32'h55, 1'b0, 32'h0);
    wait_idle();
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h8; wdata = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_ready", {31'b0, ready}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    check("abort_data2", dut.data[2], 32'h55);
    issue(1'b0, 4'h0, 32'h8, 32'h0, 1'b0, 32'h55);

    // Latency sweep on LAT=1 and LAT=4 instances
    wait_idle();
    @(negedge clk);
    we = 1'b0; addr = 32'h2; req1 = 1'b1; req4 = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    @(negedge clk);
    req1 = 1'b0; req4 = 1'b0;
    r1 = -1; r4 = -1; p1 = 0; p4 = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready1 === 1'b1) begin
        p1++;
        if (r1 < 0) r1 = cyc;
      end
      if (ready4 === 1'b1) begin
        p4++;
        if (r4 < 0) r4 = cyc;
      end
      @(negedge clk);
    end
    check("lat1_ready_cycle", 32'(r1), 32'(n + 1));
    check("lat4_ready_cycle", 32'(r4), 32'(n + 4));
    check("lat1_pulses", 32'(p1), 32'h1);
    check("lat4_pulses", 32'(p4), 32'h1);

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
